// File: rtl/flex_stp_deser.sv
// flex_stp_deser: serial-to-parallel deserializer.
// Accepts LANE_BITS bits per beat and packs NUM_BEATS beats into one word.
// Completed words go into a single holding register with a valid/ready handshake.
// A sticky overrun flag records any completed word that had to be dropped.
module flex_stp_deser #(
  parameter int LANE_BITS = 1,
  parameter int NUM_BEATS = 8,
  parameter int SHIFT_MSB = 1,
  localparam int W        = LANE_BITS * NUM_BEATS,
  localparam int CNT_W    = $clog2(NUM_BEATS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 shift_enable,
  input  logic [LANE_BITS-1:0] serial_in,
  input  logic                 out_ready,
  output logic [W-1:0]         parallel_out,
  output logic                 out_valid,
  output logic                 overrun,
  output logic [CNT_W-1:0]     beat_count
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  // Direction-dependent insertion of one beat into the partial word.
  function automatic logic [W-1:0] shift_beat(input logic [W-1:0] sr,
                                              input logic [LANE_BITS-1:0] din);
    if (SHIFT_MSB != 0) begin
      return {sr[W-LANE_BITS-1:0], din};
    end else begin
      return {din, sr[W-1:LANE_BITS]};
    end
  endfunction

  logic [W-1:0]     sr_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [W-1:0]     word_p1;
  logic             vld_p1;
  logic             ovr_p1;

  logic [W-1:0]     sr_next;
  logic             complete;

  // Next partial word and completion detect for the beat presented this cycle.
  always_comb begin
    sr_next  = shift_beat(sr_p0, serial_in);
    complete = shift_enable && (cnt_p0 == LAST_BEAT);
  end

  // Stage p0: shift register and beat counter.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr_p0  <= '0;
      cnt_p0 <= '0;
    end else if (shift_enable) begin
      sr_p0  <= sr_next;
      cnt_p0 <= complete ? '0 : cnt_p0 + CNT_W'(1);
    end
  end

  // Stage p1: holding register, handshake and sticky overrun.
  // A completion may reuse the slot in the very cycle it is being consumed.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word_p1 <= '0;
      vld_p1  <= 1'b0;
      ovr_p1  <= 1'b0;
    end else if (complete) begin
      if (!vld_p1 || out_ready) begin
        word_p1 <= sr_next;
        vld_p1  <= 1'b1;
      end else begin
        ovr_p1  <= 1'b1;
      end
    end else if (vld_p1 && out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign parallel_out = word_p1;
  assign out_valid    = vld_p1;
  assign overrun      = ovr_p1;
  assign beat_count   = cnt_p0;

endmodule

// File: tb/tb_flex_stp_deser.sv
// Bench for flex_stp_deser: three configurations (1x8 MSB, 1x8 LSB, 4x2 MSB)
// run side by side, checked against a beat-list reference model plus directed cases.
module tb_flex_stp_deser;

  localparam int LB  [3] = '{1, 1, 4};
  localparam int NB  [3] = '{8, 8, 2};
  localparam int MSB [3] = '{1, 0, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] clr = '0;
  logic [2:0] se  = '0;
  logic [2:0] rdy = 3'b111;
  logic [3:0] sinv [3];

  logic [7:0] po0, po1, po2;
  logic       vld0, vld1, vld2;
  logic       ovr0, ovr1, ovr2;
  logic [2:0] cnt0, cnt1;
  logic [0:0] cnt2;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [3:0]  mb   [3][8];
  int          mcnt [3];
  logic [31:0] mpo  [3];
  logic        mvld [3];
  logic        movr [3];

  always #5 clk = ~clk;

  flex_stp_deser #(.LANE_BITS(1), .NUM_BEATS(8), .SHIFT_MSB(1)) u_msb (
    .clk(clk), .rst(rst), .clear(clr[0]), .shift_enable(se[0]),
    .serial_in(sinv[0][0:0]), .out_ready(rdy[0]), .parallel_out(po0),
    .out_valid(vld0), .overrun(ovr0), .beat_count(cnt0));

  flex_stp_deser #(.LANE_BITS(1), .NUM_BEATS(8), .SHIFT_MSB(0)) u_lsb (
    .clk(clk), .rst(rst), .clear(clr[1]), .shift_enable(se[1]),
    .serial_in(sinv[1][0:0]), .out_ready(rdy[1]), .parallel_out(po1),
    .out_valid(vld1), .overrun(ovr1), .beat_count(cnt1));

  flex_stp_deser #(.LANE_BITS(4), .NUM_BEATS(2), .SHIFT_MSB(1)) u_nib (
    .clk(clk), .rst(rst), .clear(clr[2]), .shift_enable(se[2]),
    .serial_in(sinv[2]), .out_ready(rdy[2]), .parallel_out(po2),
    .out_valid(vld2), .overrun(ovr2), .beat_count(cnt2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word assembled from the stored beat list; first beat is most significant
  // in MSB mode and least significant in LSB mode.
  function automatic logic [31:0] assemble(input int i);
    logic [31:0] w = '0;
    for (int j = 0; j < NB[i]; j++) begin
      if (MSB[i] != 0) w = w | (32'(mb[i][j]) << (LB[i] * (NB[i] - 1 - j)));
      else             w = w | (32'(mb[i][j]) << (LB[i] * j));
    end
    return w;
  endfunction

  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      if (rst || clr[i]) begin
        mcnt[i] = 0; mvld[i] = 1'b0; movr[i] = 1'b0; mpo[i] = '0;
      end else begin
        bit done = 1'b0;
        logic [31:0] w = '0;
        if (se[i]) begin
          mb[i][mcnt[i]] = sinv[i] & 4'((1 << LB[i]) - 1);
          mcnt[i]++;
          if (mcnt[i] == NB[i]) begin
            done = 1'b1;
            w = assemble(i);
            mcnt[i] = 0;
          end
        end
        if (done) begin
          if (!mvld[i] || rdy[i]) begin
            mpo[i] = w; mvld[i] = 1'b1;
          end else begin
            movr[i] = 1'b1;
          end
        end else if (mvld[i] && rdy[i]) begin
          mvld[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("msb_po",  32'(po0),  mpo[0]);
    check("msb_vld", 32'(vld0), 32'(mvld[0]));
    check("msb_ovr", 32'(ovr0), 32'(movr[0]));
    check("msb_cnt", 32'(cnt0), 32'(mcnt[0]));
    check("lsb_po",  32'(po1),  mpo[1]);
    check("lsb_vld", 32'(vld1), 32'(mvld[1]));
    check("lsb_ovr", 32'(ovr1), 32'(movr[1]));
    check("lsb_cnt", 32'(cnt1), 32'(mcnt[1]));
    check("nib_po",  32'(po2),  mpo[2]);
    check("nib_vld", 32'(vld2), 32'(mvld[2]));
    check("nib_ovr", 32'(ovr2), 32'(movr[2]));
    check("nib_cnt", 32'(cnt2), 32'(mcnt[2]));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  // Serial bits of a byte, MSB first, into the selected 1-bit instances.
  task automatic send_byte(input logic [7:0] b, input logic [2:0] mask);
    for (int k = 7; k >= 0; k--) begin
      se = mask;
      sinv[0] = {3'b0, b[k]};
      sinv[1] = {3'b0, b[k]};
      step();
    end
    se = '0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      sinv[i] = '0; mcnt[i] = 0; mpo[i] = '0; mvld[i] = 1'b0; movr[i] = 1'b0;
      for (int j = 0; j < 8; j++) mb[i][j] = '0;
    end

    // reset state
    rst = 1'b1;
    step();
    step();
    check("rst_po0", 32'(po0), 32'h0);
    check("rst_vld0", 32'(vld0), 32'h0);
    check("rst_cnt0", 32'(cnt0), 32'h0);
    rst = 1'b0;

    // B2 into MSB and LSB instances, consumer always ready
    rdy = 3'b111;
    send_byte(8'hB2, 3'b011);
    check("t1_po_msb", 32'(po0), 32'hB2);
    check("t1_po_lsb", 32'(po1), 32'h4D);
    check("t1_vld", 32'(vld0), 32'h1);
    check("t1_cnt", 32'(cnt0), 32'h0);
    step();
    check("t1_vld_one_cycle", 32'(vld0), 32'h0);

    // 4-bit lanes with a gap between beats
    se = 3'b100; sinv[2] = 4'hA;
    step();
    se = '0;
    for (int g = 0; g < 3; g++) begin
      step();
      check("t3_cnt_gap", 32'(cnt2), 32'h1);
      check("t3_vld_gap", 32'(vld2), 32'h0);
    end
    se = 3'b100; sinv[2] = 4'h5;
    step();
    se = '0;
    check("t3_po", 32'(po2), 32'hA5);
    check("t3_vld", 32'(vld2), 32'h1);

    // backpressure and overrun, then clear
    rdy[0] = 1'b0;
    send_byte(8'hB2, 3'b001);
    send_byte(8'h3C, 3'b001);
    check("bp_po", 32'(po0), 32'hB2);
    check("bp_vld", 32'(vld0), 32'h1);
    check("bp_ovr", 32'(ovr0), 32'h1);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    check("clr_vld", 32'(vld0), 32'h0);
    check("clr_ovr", 32'(ovr0), 32'h0);

    // consume on the same edge as the next completion
    send_byte(8'hB2, 3'b001);
    check("sim_pre_vld", 32'(vld0), 32'h1);
    for (int k = 7; k >= 0; k--) begin
      logic [7:0] b = 8'h3C;
      se = 3'b001; sinv[0] = {3'b0, b[k]};
      rdy[0] = (k == 0);
      step();
    end
    se = '0;
    check("sim_vld", 32'(vld0), 32'h1);
    check("sim_po", 32'(po0), 32'h3C);
    check("sim_ovr", 32'(ovr0), 32'h0);
    rdy[0] = 1'b1;
    step();

    // reset in the middle of a word leaves no residue
    for (int k = 0; k < 3; k++) begin
      se = 3'b001; sinv[0] = 4'h1;
      step();
    end
    se = '0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_cnt", 32'(cnt0), 32'h0);
    check("mid_rst_po", 32'(po0), 32'h0);
    check("mid_rst_vld", 32'(vld0), 32'h0);
    send_byte(8'hF0, 3'b001);
    check("mid_rst_word", 32'(po0), 32'hF0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 3; i++) begin
        clr[i]  = ($urandom_range(0, 99) == 0);
        se[i]   = ($urandom_range(0, 3) != 0);
        rdy[i]  = ($urandom_range(0, 2) != 0);
        sinv[i] = 4'($urandom);
      end
      step();
    end
    rst = 1'b0; clr = '0; se = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
